// File: rtl/wb_intercon_pkg.sv
// Shared definitions for the parametrised Wishbone interconnect.
package wb_intercon_pkg;

  localparam int unsigned MAX_SLAVES = 8;
  localparam int unsigned ADR_W      = 32;
  localparam int unsigned CNT_W      = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACTIVE = 2'd1;
  localparam state_t RESP   = 2'd2;
  localparam state_t ERR    = 2'd3;

  // True when the masked address equals the slave's base address.
  function automatic logic slave_match(input logic [ADR_W-1:0] adr,
                                       input logic [ADR_W-1:0] addr,
                                       input logic [ADR_W-1:0] mask);
    return (adr & mask) == addr;
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: one-hot grant, lowest matching index wins.
module wb_addr_decode
  import wb_intercon_pkg::*;
#(
  parameter int unsigned                 NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_ADDR = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_MASK = {NUM_SLAVES{32'hFFFFFFFF}}
) (
  input  logic [ADR_W-1:0]      adr,
  output logic [NUM_SLAVES-1:0] grant,
  output logic                  hit
);

  // Priority scan from slave 0 upward; first match takes the grant.
  always_comb begin
    grant = '0;
    hit   = 1'b0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (!hit && slave_match(adr, SLAVE_ADDR[ADR_W*k +: ADR_W],
                              SLAVE_MASK[ADR_W*k +: ADR_W])) begin
        grant[k] = 1'b1;
        hit      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_intercon_n.sv
// Single-master Wishbone classic interconnect with address decode,
// bus watchdog and sticky fault-address capture.
module wb_intercon_n
  import wb_intercon_pkg::*;
#(
  parameter int unsigned                 DATA_WIDTH = 16,
  parameter int unsigned                 NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_ADDR = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_MASK = {NUM_SLAVES{32'hFFFFFFFF}},
  parameter int unsigned                 TIMEOUT    = 255,
  localparam int unsigned                SEL_WIDTH  = DATA_WIDTH/8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [ADR_W-1:0]                 wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]            wbm_dat_i,
  output logic [DATA_WIDTH-1:0]            wbm_dat_o,
  input  logic [SEL_WIDTH-1:0]             wbm_sel_i,
  input  logic                             wbm_we_i,
  input  logic                             wbm_cyc_i,
  input  logic                             wbm_stb_i,
  output logic                             wbm_ack_o,
  output logic                             wbm_err_o,
  output logic [ADR_W-1:0]                 wbs_adr_o,
  output logic [DATA_WIDTH-1:0]            wbs_dat_o,
  output logic [SEL_WIDTH-1:0]             wbs_sel_o,
  output logic                             wbs_we_o,
  output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]            wbs_stb_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
  output logic                             fault_o,
  output logic [ADR_W-1:0]                 fault_adr_o,
  input  logic                             fault_clr_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                  state_q, state_n;
  logic                    ack_q, ack_n;
  logic                    err_q, err_n;
  logic [DATA_WIDTH-1:0]   rdat_q, rdat_n;
  logic [ADR_W-1:0]        adr_q, adr_n;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_n;
  logic [SEL_WIDTH-1:0]    sel_q, sel_n;
  logic                    we_q, we_n;
  logic [NUM_SLAVES-1:0]   grant_q, grant_n;
  logic [CNT_W-1:0]        cnt_q, cnt_n;
  logic                    fault_q, fault_n;
  logic [ADR_W-1:0]        fault_adr_q, fault_adr_n;

  logic [NUM_SLAVES-1:0]   dec_grant;
  logic                    dec_hit;
  logic                    ack_hit;
  logic [DATA_WIDTH-1:0]   slv_dat;

  wb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_ADDR (SLAVE_ADDR),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .adr   (wbm_adr_i),
    .grant (dec_grant),
    .hit   (dec_hit)
  );

  // Only the granted slave's ack counts; others are ignored.
  assign ack_hit = |(wbs_ack_i & grant_q);

  // Read-data mux driven by the registered one-hot grant.
  always_comb begin
    slv_dat = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (grant_q[k]) slv_dat = slv_dat | wbs_dat_i[DATA_WIDTH*k +: DATA_WIDTH];
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdat_q      <= '0;
      adr_q       <= '0;
      wdat_q      <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      grant_q     <= '0;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
      fault_adr_q <= '0;
    end else begin
      state_q     <= state_n;
      ack_q       <= ack_n;
      err_q       <= err_n;
      rdat_q      <= rdat_n;
      adr_q       <= adr_n;
      wdat_q      <= wdat_n;
      sel_q       <= sel_n;
      we_q        <= we_n;
      grant_q     <= grant_n;
      cnt_q       <= cnt_n;
      fault_q     <= fault_n;
      fault_adr_q <= fault_adr_n;
    end
  end

  // Next-state and next-output logic; responses are one-cycle pulses.
  always_comb begin
    state_n     = state_q;
    ack_n       = 1'b0;
    err_n       = 1'b0;
    rdat_n      = rdat_q;
    adr_n       = adr_q;
    wdat_n      = wdat_q;
    sel_n       = sel_q;
    we_n        = we_q;
    grant_n     = grant_q;
    cnt_n       = cnt_q;
    fault_n     = fault_q;
    fault_adr_n = fault_adr_q;

    case (state_q)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          adr_n  = wbm_adr_i;
          wdat_n = wbm_dat_i;
          sel_n  = wbm_sel_i;
          we_n   = wbm_we_i;
          if (dec_hit) begin
            grant_n = dec_grant;
            cnt_n   = '0;
            state_n = ACTIVE;
          end else begin
            err_n   = 1'b1;
            state_n = ERR;
          end
        end
      end
      ACTIVE: begin
        if (!wbm_cyc_i) begin
          grant_n = '0;
          state_n = IDLE;
        end else if (ack_hit) begin
          if (!we_q) rdat_n = slv_dat;
          grant_n = '0;
          ack_n   = 1'b1;
          state_n = RESP;
        end else if (cnt_q == CNT_LAST) begin
          grant_n = '0;
          err_n   = 1'b1;
          state_n = ERR;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Sticky fault flag: first fault address is kept, set beats clear.
    if (state_q == ERR) begin
      fault_n = 1'b1;
      if (!fault_q) fault_adr_n = adr_q;
    end else if (fault_clr_i) begin
      fault_n = 1'b0;
    end
  end

  assign wbm_ack_o   = ack_q;
  assign wbm_err_o   = err_q;
  assign wbm_dat_o   = rdat_q;
  assign wbs_adr_o   = adr_q;
  assign wbs_dat_o   = wdat_q;
  assign wbs_sel_o   = sel_q;
  assign wbs_we_o    = we_q;
  assign wbs_cyc_o   = grant_q;
  assign wbs_stb_o   = grant_q;
  assign fault_o     = fault_q;
  assign fault_adr_o = fault_adr_q;

endmodule

// File: doc/wb_intercon_n.md
Name: wb_intercon_n

Overview:
- Parametrised single-master Wishbone classic interconnect; successor to the fixed 4-slave decoder used in the SoC top level.
- Decodes the master address against NUM_SLAVES programmable address/mask pairs and routes one transaction at a time.
- Absorbs the bus watchdog: returns a Wishbone error on unmapped addresses or slave timeout, and latches the faulting address.
- Sits between the CPU core (moxielite_wb) and all bus slaves.

Parameters:
- DATA_WIDTH, 16, data bus width; multiple of 8. SEL_WIDTH = DATA_WIDTH/8.
- NUM_SLAVES, 4, number of slave ports; range 1..8.
- SLAVE_ADDR, {NUM_SLAVES{32'h0}}, packed base addresses; slave k at bits [32k+31:32k].
- SLAVE_MASK, {NUM_SLAVES{32'hFFFFFFFF}}, packed masks; slave k matches when (adr & mask_k) == addr_k.
- TIMEOUT, 255, cycles in ACTIVE without ack before an error; range 2..65535.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- wbm_adr_i  in  32  master address.
- wbm_dat_i  in  DATA_WIDTH  master write data.
- wbm_dat_o  out  DATA_WIDTH  read data to master.
- wbm_sel_i  in  SEL_WIDTH  byte selects.
- wbm_we_i / wbm_cyc_i / wbm_stb_i  in  1 each  master controls.
- wbm_ack_o  out  1  transfer complete.
- wbm_err_o  out  1  transfer error.
- wbs_adr_o  out  32  address, shared by all slaves.
- wbs_dat_o  out  DATA_WIDTH  write data, shared.
- wbs_sel_o  out  SEL_WIDTH  byte selects, shared.
- wbs_we_o  out  1  write enable, shared.
- wbs_cyc_o  out  NUM_SLAVES  per-slave cyc.
- wbs_stb_o  out  NUM_SLAVES  per-slave stb.
- wbs_dat_i  in  NUM_SLAVES*DATA_WIDTH  packed slave read data.
- wbs_ack_i  in  NUM_SLAVES  per-slave ack.
- fault_o  out  1  sticky fault flag.
- fault_adr_o  out  32  address of the first unacknowledged fault.
- fault_clr_i  in  1  clears fault_o.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state=IDLE. wbm_ack_o=0, wbm_err_o=0, wbm_dat_o=0. wbs_cyc_o=0, wbs_stb_o=0. Shared slave buses=0. fault_o=0, fault_adr_o=0. Timeout counter=0.
- All master-facing and slave-facing outputs are registered.
- IDLE: when wbm_cyc_i & wbm_stb_i:
  - latch adr, dat, sel and we onto the shared slave buses;
  - compute a one-hot grant; lowest matching index wins on overlap;
  - any match: set cyc/stb for the granted slave, clear the counter, go to ACTIVE;
  - no match: go to ERR.
- ACTIVE:
  - counter increments each cycle.
  - wbs_ack_i[grant]=1: capture that slave's data into wbm_dat_o, drop cyc/stb, go to RESP.
  - else if counter == TIMEOUT-1: drop cyc/stb, go to ERR.
  - Ack and timeout in the same cycle: ack wins.
  - Acks from non-granted slaves are ignored.
- RESP: wbm_ack_o=1 for exactly one cycle, then IDLE.
- ERR: wbm_err_o=1 for exactly one cycle, then IDLE.
  - If fault_o=0, set fault_o and load fault_adr_o with the latched address.
  - If fault_o=1, fault_adr_o keeps the earlier value.
- Abort: wbm_cyc_i deasserted in ACTIVE → next cycle all slave cyc/stb=0, state=IDLE, no ack and no err.
- Latency, zero-wait slave: request seen in cycle 0 → slave stb in cycle 1 → wbm_ack_o in cycle 2. The master can issue the next request in cycle 3.
- Back-to-back: a new request is sampled in the first IDLE cycle after RESP/ERR.
- Writes: wbm_dat_o holds its last value.
- fault_clr_i clears fault_o in IDLE or any state. Fault set and clear in the same cycle: set wins.
- Reset mid-transaction: all strobes drop on the next edge, no response is issued.

Decomposition:
- Shared package wb_intercon_pkg:
  - state enum {IDLE, ACTIVE, RESP, ERR};
  - MAX_SLAVES=8;
  - helper function slave_match(adr, addr, mask).
- Sub-module wb_addr_decode (combinational): inputs adr, SLAVE_ADDR and SLAVE_MASK; outputs one-hot grant and hit.

Test Plan:
- Read, default map (slave0 0x00001000/0xFFFFF000), adr=0x00001004, slave0 acks in cycle 1 with 0xBEEF → wbm_ack_o in cycle 2, wbm_dat_o=0xBEEF, only wbs_stb_o[0] ever high.
- Write to 0xF0000004 (slave2), dat=0x1234, sel=2'b11 → wbs_stb_o=4'b0100 with matching adr/dat/sel/we=1; ack returned; fault_o stays 0.
- Unmapped read at 0x20000000 → no slave strobe; wbm_err_o pulse one cycle after the request; fault_o=1, fault_adr_o=0x20000000.
- TIMEOUT=8, slave1 never acks → slave stb high exactly 8 cycles, then wbm_err_o; fault_adr_o set. A second fault does not overwrite it; fault_clr_i clears fault_o.
- Overlap: slave0 and slave3 both match 0x1000 → only slave0 granted. Ack from slave3 in the same cycle is ignored; transaction completes on slave0's ack.
- Abort and reset: wbm_cyc_i dropped in ACTIVE → strobes low next cycle, no ack or err. rst_i mid-ACTIVE → all outputs at reset values next cycle.
